plen_generator: RTL and testbench

//  Stimulus source for the packet-length stream. Emits plen_tdata/plen_tvalid/plen_tuser

---
 rtl/plen_gen_pkg.sv | 18 +
 rtl/plen_lfsr.sv | 32 +++
 rtl/plen_generator.sv | 176 +++++++++++++++++
 tb/tb_plen_generator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plen_gen_pkg.sv
// Package: plen_gen_pkg
// Shared types and constants for the packet-length stimulus generator.
//   state_t      - run FSM states (IDLE, EMIT, GAP, DONE)
//   LFSR_TAPS    - Galois feedback mask for the 16-bit length LFSR
//   LFSR_DEFAULT - LFSR reset value, also substituted for a zero seed
package plen_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

endpackage

// File: rtl/plen_lfsr.sv
// Module: plen_lfsr
// 16-bit right-shifting Galois LFSR used for pseudo-random packet lengths.
// Ports:
//   clk      in   clock
//   resetn   in   asynchronous active-low reset (value -> LFSR_DEFAULT)
//   load     in   load seed (zero seed is replaced by LFSR_DEFAULT)
//   advance  in   step the LFSR once
//   seed     in   16-bit seed
//   value    out  current LFSR state
module plen_lfsr
  import plen_gen_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= LFSR_DEFAULT;
    end else if (load) begin
      // An all-zero state would lock the LFSR, so zero is remapped.
      value <= (seed == 16'd0) ? LFSR_DEFAULT : seed;
    end else if (advance) begin
      value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
    end
  end

endmodule

// File: rtl/plen_generator.sv
// Module: plen_generator
// Packet-length stimulus source. Emits cfg_count records on a valid/ready
// stream with lengths either swept over [len_lo,len_hi] or, when built with
// PLEN_GEN_LFSR_EN defined and cfg_random=1, drawn from an LFSR. Every Nth
// record can be flagged bad and idle gaps can follow each accepted record.
// Build option:
//   PLEN_GEN_LFSR_EN - adds the LFSR length mode (cfg_random/cfg_seed);
//                      without it the block is sweep-only.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start, abort           run control pulses (abort wins over start)
//   cfg_*                  run configuration, latched on an accepted start
//   plen_tdata/tvalid/tuser/tready  record stream (tuser = bad packet)
//   busy                   run in progress (EMIT/GAP/DONE)
//   done                   one-cycle pulse on normal completion
//   sent_count             records accepted in the current/last run
module plen_generator
  import plen_gen_pkg::*;
#(
  parameter int LW = 16,
  parameter int CW = 32,
  parameter int GW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] cfg_count,
  input  logic [LW-1:0] cfg_len_lo,
  input  logic [LW-1:0] cfg_len_hi,
  input  logic [LW-1:0] cfg_step,
  input  logic          cfg_random,
  input  logic [15:0]   cfg_seed,
  input  logic [15:0]   cfg_bad_every,
  input  logic [GW-1:0] cfg_gap,
  output logic [LW-1:0] plen_tdata,
  output logic          plen_tvalid,
  output logic          plen_tuser,
  input  logic          plen_tready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sent_count
);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q;
  logic [LW-1:0] lo_q, hi_q, step_q;
  logic [15:0]   bad_every_q, bad_cnt;
  logic [GW-1:0] gap_q, gap_cnt;
  logic [LW-1:0] cur_len;
  logic          start_acc, hs, last;

  // Next sweep length; the sum is formed one bit wider so it cannot wrap
  // before being compared against the upper bound.
  function automatic logic [LW-1:0] sweep_next(input logic [LW-1:0] cur,
                                               input logic [LW-1:0] lo,
                                               input logic [LW-1:0] hi,
                                               input logic [LW-1:0] step);
    logic [LW:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (step == '0 || lo >= hi)
      return lo;
    else if (sum > {1'b0, hi})
      return lo;
    else
      return sum[LW-1:0];
  endfunction

  assign start_acc   = start && !abort && (state_q == IDLE);
  assign plen_tvalid = (state_q == EMIT);
  assign hs          = plen_tvalid && plen_tready;
  assign last        = ((sent_count + CW'(1)) == count_q);
  assign plen_tuser  = plen_tvalid && (bad_every_q != 16'd0) && (bad_cnt == 16'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = (cfg_count == '0) ? DONE : EMIT;
        EMIT: if (plen_tready) begin
          if (last)             state_d = DONE;
          else if (gap_q != '0) state_d = GAP;
          else                  state_d = EMIT;
        end
        GAP:  if (gap_cnt <= GW'(1)) state_d = EMIT;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q     <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      step_q      <= '0;
      bad_every_q <= '0;
      bad_cnt     <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      cur_len     <= '0;
      sent_count  <= '0;
    end else if (start_acc) begin
      count_q     <= cfg_count;
      lo_q        <= cfg_len_lo;
      hi_q        <= cfg_len_hi;
      step_q      <= cfg_step;
      bad_every_q <= cfg_bad_every;
      bad_cnt     <= cfg_bad_every;
      gap_q       <= cfg_gap;
      gap_cnt     <= '0;
      cur_len     <= cfg_len_lo;
      sent_count  <= '0;
    end else if (!abort) begin
      if (hs) begin
        sent_count <= sent_count + CW'(1);
        cur_len    <= sweep_next(cur_len, lo_q, hi_q, step_q);
        gap_cnt    <= gap_q;
        // Down-counter hits 1 on every bad_every-th record, then reloads.
        if (bad_cnt == 16'd1)       bad_cnt <= bad_every_q;
        else if (bad_cnt != 16'd0)  bad_cnt <= bad_cnt - 16'd1;
      end else if (state_q == GAP) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

`ifdef PLEN_GEN_LFSR_EN
  logic          random_q;
  logic [15:0]   lfsr_val;
  logic [LW:0]   span;
  logic [LW+16:0] product;
  logic [LW:0]   scaled;
  logic [LW:0]   lfsr_sum;
  logic [LW-1:0] lfsr_len;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        random_q <= 1'b0;
    else if (start_acc) random_q <= cfg_random;
  end

  plen_lfsr u_lfsr (
    .clk     (clk),
    .resetn  (resetn),
    .load    (start_acc),
    .advance (hs),
    .seed    (cfg_seed),
    .value   (lfsr_val)
  );

  // Scale the LFSR value into [0,span) with a multiply-and-shift so no
  // divider is needed; the result always lands in [lo,hi].
  assign span     = {1'b0, hi_q} - {1'b0, lo_q} + (LW+1)'(1);
  assign product  = (LW+17)'(lfsr_val) * (LW+17)'(span);
  assign scaled   = (LW+1)'(product >> 16);
  assign lfsr_sum = {1'b0, lo_q} + scaled;
  assign lfsr_len = (lo_q > hi_q) ? lo_q : lfsr_sum[LW-1:0];

  assign plen_tdata = random_q ? lfsr_len : cur_len;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_random, cfg_seed};
  assign plen_tdata = cur_len;
`endif

endmodule

// File: tb/tb_plen_generator.sv
module tb_plen_generator;
  localparam int LW = 16;
  localparam int CW = 32;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [CW-1:0] cfg_count = '0;
  logic [LW-1:0] cfg_len_lo = '0, cfg_len_hi = '0, cfg_step = '0;
  logic          cfg_random = 1'b0;
  logic [15:0]   cfg_seed = '0, cfg_bad_every = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic [LW-1:0] plen_tdata;
  logic          plen_tvalid, plen_tuser;
  logic          plen_tready = 1'b1;
  logic          busy, done;
  logic [CW-1:0] sent_count;

  int total = 0;
  int bad = 0;

  plen_generator #(.LW(LW), .CW(CW), .GW(GW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cfg_count(cfg_count), .cfg_len_lo(cfg_len_lo), .cfg_len_hi(cfg_len_hi),
    .cfg_step(cfg_step), .cfg_random(cfg_random), .cfg_seed(cfg_seed),
    .cfg_bad_every(cfg_bad_every), .cfg_gap(cfg_gap),
    .plen_tdata(plen_tdata), .plen_tvalid(plen_tvalid), .plen_tuser(plen_tuser),
    .plen_tready(plen_tready), .busy(busy), .done(done), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int cnt, input int lo, input int hi, input int step,
                     input int bad_every, input int gap);
    cfg_count     = CW'(cnt);
    cfg_len_lo    = LW'(lo);
    cfg_len_hi    = LW'(hi);
    cfg_step      = LW'(step);
    cfg_bad_every = 16'(bad_every);
    cfg_gap       = GW'(gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_len [6];
    int idle;
    exp_len = '{64, 128, 192, 256, 64, 128};

    // Reset state
    #12;
    chk("rst_tvalid", plen_tvalid, 0);
    chk("rst_tdata", plen_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", sent_count, 0);
    resetn = 1'b1;
    tick();

    // 1: sweep, back-to-back
    cfg(6, 64, 256, 64, 0, 0);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("sw_vld%0d", i), plen_tvalid, 1);
      chk($sformatf("sw_dat%0d", i), plen_tdata, exp_len[i]);
      chk($sformatf("sw_usr%0d", i), plen_tuser, 0);
      tick();
    end
    chk("sw_done", done, 1);
    chk("sw_vld_end", plen_tvalid, 0);
    chk("sw_sent", sent_count, 6);
    tick();
    chk("sw_done_once", done, 0);
    chk("sw_idle", busy, 0);

    // 2: bad flags and gaps
    cfg(5, 10, 20, 1, 2, 3);
    pulse_start();
    for (int r = 0; r < 5; r++) begin
      chk($sformatf("bg_vld%0d", r), plen_tvalid, 1);
      chk($sformatf("bg_dat%0d", r), plen_tdata, 10 + r);
      chk($sformatf("bg_usr%0d", r), plen_tuser, (r % 2 == 1) ? 1 : 0);
      tick();
      if (r < 4) begin
        idle = 0;
        while (!plen_tvalid && idle < 20) begin
          idle++;
          tick();
        end
        chk($sformatf("bg_gap%0d", r), idle, 3);
      end else begin
        chk("bg_done", done, 1);
        chk("bg_sent", sent_count, 5);
      end
    end
    tick();

    // 3: backpressure, then empty run
    cfg(3, 5, 50, 5, 3, 0);
    pulse_start();
    chk("bp_dat0", plen_tdata, 5);
    plen_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bp_hold_vld%0d", i), plen_tvalid, 1);
      chk($sformatf("bp_hold_dat%0d", i), plen_tdata, 5);
      chk($sformatf("bp_hold_usr%0d", i), plen_tuser, 0);
    end
    chk("bp_sent_hold", sent_count, 0);
    plen_tready = 1'b1;
    tick();
    chk("bp_dat1", plen_tdata, 10);
    chk("bp_usr1", plen_tuser, 0);
    tick();
    chk("bp_dat2", plen_tdata, 15);
    chk("bp_usr2", plen_tuser, 1);
    tick();
    chk("bp_done", done, 1);
    chk("bp_sent", sent_count, 3);
    tick();
    cfg(0, 5, 50, 5, 0, 0);
    pulse_start();
    chk("empty_vld", plen_tvalid, 0);
    chk("empty_done", done, 1);
    chk("empty_sent", sent_count, 0);
    tick();
    chk("empty_done_once", done, 0);
    chk("empty_vld2", plen_tvalid, 0);

    // 4: abort after 3 of 10, then a new run of 2
    cfg(10, 100, 1000, 100, 0, 0);
    pulse_start();
    tick(); tick(); tick();
    chk("ab_sent3", sent_count, 3);
    chk("ab_dat3", plen_tdata, 400);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_vld", plen_tvalid, 0);
    chk("ab_done", done, 0);
    chk("ab_sent_kept", sent_count, 3);
    tick();
    chk("ab_done2", done, 0);
    cfg(2, 100, 1000, 100, 0, 0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_wins", busy, 0);
    pulse_start();
    chk("ab_new_dat0", plen_tdata, 100);
    tick();
    chk("ab_new_dat1", plen_tdata, 200);
    tick();
    chk("ab_new_done", done, 1);
    chk("ab_new_sent", sent_count, 2);
    tick();

    // 5: random mode
`ifdef PLEN_GEN_LFSR_EN
    begin
      logic [15:0] v;
      int          len;
      cfg(1000, 100, 1500, 1, 0, 0);
      cfg_random = 1'b1;
      cfg_seed = 16'd1;
      v = 16'd1;
      pulse_start();
      for (int i = 0; i < 1000; i++) begin
        len = 100 + int'((longint'(v) * longint'(1401)) >>> 16);
        chk($sformatf("lf_dat%0d", i), plen_tdata, len);
        chk($sformatf("lf_rng%0d", i), (plen_tdata >= 100 && plen_tdata <= 1500), 1);
        v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        tick();
      end
      chk("lf_done", done, 1);
      cfg_random = 1'b0;
      tick();
    end
`else
    cfg(3, 100, 1500, 700, 0, 0);
    cfg_random = 1'b1;
    cfg_seed = 16'd1;
    pulse_start();
    chk("nolf_dat0", plen_tdata, 100);
    tick();
    chk("nolf_dat1", plen_tdata, 800);
    tick();
    chk("nolf_dat2", plen_tdata, 1500);
    tick();
    chk("nolf_done", done, 1);
    cfg_random = 1'b0;
    tick();
`endif

    // 6: asynchronous reset mid-EMIT
    cfg(10, 30, 300, 30, 1, 0);
    pulse_start();
    tick();
    chk("rs_pre_vld", plen_tvalid, 1);
    chk("rs_pre_usr", plen_tuser, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rs_vld", plen_tvalid, 0);
    chk("rs_dat", plen_tdata, 0);
    chk("rs_usr", plen_tuser, 0);
    chk("rs_busy", busy, 0);
    chk("rs_sent", sent_count, 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rs_idle_busy", busy, 0);
    chk("rs_idle_vld", plen_tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
